// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU: opcodes, flag layout and control states.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ZERO = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_PASS = 4'd3,
    OP_XOR  = 4'd4,
    OP_OR   = 4'd5,
    OP_AND  = 4'd6,
    OP_INC  = 4'd7,
    OP_SHL  = 4'd8,
    OP_SHR  = 4'd9,
    OP_SRA  = 4'd10,
    OP_MUL  = 4'd11
  } alu_op_e;

  typedef struct packed {
    logic err;
    logic v;
    logic c;
    logic n;
    logic z;
  } alu_flags_t;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Sequential shift-add multiplier: WIDTH iterations, one per clock.
// product/done are combinational views of the accumulator including the
// current iteration, so the caller can capture the final value on the
// same edge that performs the last iteration.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic               busy;

  assign product = acc + (mplier[0] ? mcand : '0);
  assign done    = busy && (cnt == LAST);

  // One partial product per cycle; a start always restarts from a clean state.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (start) begin
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      cnt    <= '0;
      busy   <= 1'b1;
    end else if (busy) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Single-slot pipelined ALU with valid/ready handshakes on both sides.
// Single-cycle ops load the output register on the accept edge; multiply
// hands off to a sequential multiplier and blocks new work until it ends.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       Sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Q,
  output logic [4:0]       Flags
);

  localparam int MSB = WIDTH - 1;
  localparam int SHW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] W_VAL = WIDTH'(WIDTH);

  state_e             state;
  alu_flags_t         flags_r;
  alu_flags_t         flags_c;
  alu_flags_t         mul_flags;
  logic [WIDTH-1:0]   res_c;
  logic [WIDTH:0]     sum_ext;
  logic [SHW-1:0]     sh;
  logic               sh_big;
  logic               accept;
  logic               is_mul;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;

  // Z and N derive from the result; V and C come from the operation.
  function automatic alu_flags_t result_flags(input logic v, input logic c,
                                              input logic [WIDTH-1:0] r);
    result_flags = '{err: 1'b0, v: v, c: c, n: r[MSB], z: (r == '0)};
  endfunction

  assign in_ready = (state == IDLE) && (!out_valid || out_ready) && !Reset;
  assign accept   = in_valid && in_ready;
  assign is_mul   = (Sel == OP_MUL);
  assign sh       = B[SHW-1:0];
  assign sh_big   = (B >= W_VAL);
  assign Flags    = flags_r;

  assign mul_flags = result_flags(1'b0, |mul_product[2*WIDTH-1:WIDTH],
                                  mul_product[WIDTH-1:0]);

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (Clk),
    .reset   (Reset),
    .start   (accept && is_mul),
    .a       (A),
    .b       (B),
    .done    (mul_done),
    .product (mul_product)
  );

  // Single-cycle datapath: result and flags for the opcode on the inputs.
  // NOTE: every output of this block is given a default first, so no path
  // through the case can leave a value held and infer a latch.
  always_comb begin
    res_c   = '0;
    sum_ext = '0;
    flags_c = '0;
    case (alu_op_e'(Sel))
      OP_ZERO: flags_c = result_flags(1'b0, 1'b0, '0);
      OP_ADD: begin
        sum_ext = {1'b0, A} + {1'b0, B};
        res_c   = sum_ext[WIDTH-1:0];
        flags_c = result_flags((A[MSB] == B[MSB]) && (res_c[MSB] != A[MSB]),
                               sum_ext[WIDTH], res_c);
      end
      OP_SUB: begin
        sum_ext = {1'b0, A} - {1'b0, B};
        res_c   = sum_ext[WIDTH-1:0];
        flags_c = result_flags((A[MSB] != B[MSB]) && (res_c[MSB] != A[MSB]),
                               (A < B), res_c);
      end
      OP_PASS: begin res_c = A;     flags_c = result_flags(1'b0, 1'b0, res_c); end
      OP_XOR:  begin res_c = A ^ B; flags_c = result_flags(1'b0, 1'b0, res_c); end
      OP_OR:   begin res_c = A | B; flags_c = result_flags(1'b0, 1'b0, res_c); end
      OP_AND:  begin res_c = A & B; flags_c = result_flags(1'b0, 1'b0, res_c); end
      OP_INC: begin
        sum_ext = {1'b0, A} + 1'b1;
        res_c   = sum_ext[WIDTH-1:0];
        flags_c = result_flags(!A[MSB] && res_c[MSB], sum_ext[WIDTH], res_c);
      end
      OP_SHL: begin
        res_c   = sh_big ? '0 : (A << sh);
        flags_c = result_flags(1'b0, 1'b0, res_c);
      end
      OP_SHR: begin
        res_c   = sh_big ? '0 : (A >> sh);
        flags_c = result_flags(1'b0, 1'b0, res_c);
      end
      OP_SRA: begin
        res_c   = sh_big ? {WIDTH{A[MSB]}} : $unsigned($signed(A) >>> sh);
        flags_c = result_flags(1'b0, 1'b0, res_c);
      end
      OP_MUL: flags_c = '0;  // result comes from the multiplier later
      default: flags_c = '{err: 1'b1, v: 1'b0, c: 1'b0, n: 1'b0, z: 1'b1};
    endcase
  end

  // Control FSM, output register and downstream handshake.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      Q         <= '0;
      flags_r   <= '0;
    end else begin
      case (state)
        IDLE: if (accept && is_mul) state <= MUL;
        MUL:  if (mul_done) state <= IDLE;
      endcase

      if (accept && !is_mul) begin
        Q         <= res_c;
        flags_r   <= flags_c;
        out_valid <= 1'b1;
      end else if (mul_done) begin
        Q         <= mul_product[WIDTH-1:0];
        flags_r   <= mul_flags;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WIDTH=16): directed corner cases plus
// randomized traffic scored against an arithmetic reference model.
module tb_alu_pipe;

  localparam int W = 16;

  logic         Clk = 1'b0;
  logic         Reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [3:0]   Sel = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] Q;
  logic [4:0]   Flags;

  int total = 0;
  int bad   = 0;

  alu_pipe #(.WIDTH(W)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Sel       (Sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Q         (Q),
    .Flags     (Flags)
  );

  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Reference: {Err,V,C,N,Z, Q} from integer arithmetic on the operands.
  function automatic logic [20:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic [3:0] op);
    int ua, ub, sa, sb, r, s;
    longint full;
    bit c, v, e;
    logic [15:0] q;
    ua = a; ub = b; sa = $signed(a); sb = $signed(b);
    r = 0; c = 0; v = 0; e = 0;
    case (op)
      4'd0:  r = 0;
      4'd1:  begin r = ua + ub; c = (r > 65535); s = sa + sb; v = (s > 32767) || (s < -32768); end
      4'd2:  begin r = ua - ub; c = (ua < ub);   s = sa - sb; v = (s > 32767) || (s < -32768); end
      4'd3:  r = ua;
      4'd4:  r = ua ^ ub;
      4'd5:  r = ua | ub;
      4'd6:  r = ua & ub;
      4'd7:  begin r = ua + 1; c = (r > 65535); v = (sa + 1 > 32767); end
      4'd8:  r = (ub >= 16) ? 0 : (ua << ub);
      4'd9:  r = (ub >= 16) ? 0 : (ua >> ub);
      4'd10: r = (ub >= 16) ? ((sa < 0) ? -1 : 0) : (sa >>> ub);
      4'd11: begin
        full = longint'(ua) * longint'(ub);
        r = int'(full & 64'hFFFF);
        c = ((full >> 16) != 0);
      end
      default: begin e = 1; r = 0; end
    endcase
    q = r[15:0];
    model = {e, v, c, q[15], (q == 16'h0), q};
  endfunction

  // Offer one operation and hold it until accepted (bounded).
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic [3:0] s);
    int n;
    n = 0;
    A = a; B = b; Sel = s; in_valid = 1'b1;
    #1;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("accept_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
  endtask

  // Issue a multiply; report edges until out_valid and cycles with in_ready low.
  task automatic mul_op(input logic [15:0] a, input logic [15:0] b,
                        output int lat, output int low);
    do_op(a, b, 4'd11);
    lat = 0;
    low = 0;
    while (!out_valid && lat < 40) begin
      if (!in_ready) low++;
      tick();
      lat++;
    end
  endtask

  logic [20:0] exp_q[$];
  logic [20:0] e;
  int lat, low, seen, accepts, n;

  initial begin
    // Reset behaviour
    Reset = 1'b1;
    repeat (3) tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_q", Q, 0);
    check("rst_flags", Flags, 0);
    Reset = 1'b0;
    #1;
    check("rst_release_ready", in_ready, 1);

    // Add with carry-out to zero
    out_ready = 1'b1;
    do_op(16'hFFFF, 16'h0001, 4'd1);
    check("add_valid", out_valid, 1);
    check("add_q", Q, 16'h0000);
    check("add_flags", Flags, 5'b00101);

    // Subtract with signed overflow, arithmetic shift beyond width
    do_op(16'h8000, 16'h0001, 4'd2);
    check("sub_q", Q, 16'h7FFF);
    check("sub_flags", Flags, 5'b01000);
    do_op(16'h8000, 16'd20, 4'd10);
    check("sra_q", Q, 16'hFFFF);
    check("sra_flags", Flags, 5'b00010);

    // Multiply latency, blocking and high-half carry
    mul_op(16'h0123, 16'h0010, lat, low);
    check("mul_latency", lat, 16);
    check("mul_ready_low", low, 16);
    check("mul_q", Q, 16'h1230);
    check("mul_flags", Flags, 5'b00000);
    mul_op(16'h1000, 16'h1000, lat, low);
    check("mul2_latency", lat, 16);
    check("mul2_q", Q, 16'h0000);
    check("mul2_flags", Flags, 5'b00101);

    // Back-pressure: result must hold, then drain back-to-back
    do_op(16'h00F0, 16'h0F0F, 4'd4);
    out_ready = 1'b0;
    A = 16'h1200; B = 16'h0034; Sel = 4'd5; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stall_ready", in_ready, 0);
      check("stall_valid", out_valid, 1);
      check("stall_q", Q, 16'h0FFF);
      check("stall_flags", Flags, 5'b00000);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("b2b_valid1", out_valid, 1);
    check("b2b_q1", Q, 16'h1234);
    A = 16'hFF00; B = 16'h0F0F; Sel = 4'd6;
    tick();
    in_valid = 1'b0;
    check("b2b_valid2", out_valid, 1);
    check("b2b_q2", Q, 16'h0F00);
    tick();
    check("b2b_no_dup", out_valid, 0);

    // Reset aborts an in-flight multiply
    do_op(16'h0123, 16'h0010, 4'd11);
    repeat (4) tick();
    Reset = 1'b1;
    #1;
    check("abort_ready_in_reset", in_ready, 0);
    tick();
    tick();
    check("abort_valid", out_valid, 0);
    check("abort_q", Q, 0);
    check("abort_flags", Flags, 0);
    Reset = 1'b0;
    #1;
    check("abort_ready_after", in_ready, 1);
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (out_valid) seen++;
    end
    check("abort_no_result", seen, 0);

    // Illegal opcode
    do_op(16'h1234, 16'h0000, 4'hE);
    check("illegal_q", Q, 0);
    check("illegal_flags", Flags, 5'b10001);
    tick();  // drain the directed result before scoring random traffic

    // Randomized traffic against the reference model
    accepts = 0;
    n = 0;
    while (accepts < 200 && n < 20000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      A         = 16'($urandom);
      B         = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom);
      Sel       = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("rnd_spurious", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("rnd_q", Q, e[15:0]);
          check("rnd_flags", Flags, e[20:16]);
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(A, B, Sel));
        accepts++;
      end
      tick();
      n++;
    end
    check("rnd_accepts", accepts, 200);

    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() > 0 && n < 100) begin
      #1;
      if (out_valid) begin
        e = exp_q.pop_front();
        check("drain_q", Q, e[15:0]);
        check("drain_flags", Flags, e[20:16]);
      end
      tick();
      n++;
    end
    check("rnd_drain_left", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, data width in bits (legal range 4..64).
REQ-002 The block SHALL have port Clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 The block SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port in_valid  input  1  operand/opcode offer.
REQ-005 The block SHALL have port in_ready  output  1  block can accept an operation this cycle.
REQ-006 The block SHALL have ports A, B  input  WIDTH each  operands.
REQ-007 The block SHALL have port Sel  input  4  opcode (alu_op_e).
REQ-008 The block SHALL have port out_valid  output  1  Q/Flags hold a result.
REQ-009 The block SHALL have port out_ready  input  1  consumer takes the result.
REQ-010 The block SHALL have port Q  output  WIDTH  registered result.
REQ-011 The block SHALL have port Flags  output  5  registered {Err, V, C, N, Z}.

Function
REQ-012 Accept SHALL occur on an edge where in_valid && in_ready; A, B and Sel are captured then.
REQ-013 in_ready SHALL be (state==IDLE) && (!out_valid || out_ready) && !Reset.
REQ-014 Opcodes SHALL be: 0 zero; 1 A+B; 2 A-B; 3 A; 4 A^B; 5 A|B; 6 A&B; 7 A+1; 8 A<<sh; 9 A>>sh logical; 10 A>>>sh arithmetic; 11 A*B low WIDTH bits; 12-15 illegal.
REQ-015 sh SHALL be B[$clog2(WIDTH)-1:0] when B < WIDTH; for B >= WIDTH, ops 8/9 give 0 and op 10 gives all copies of A[WIDTH-1].
REQ-016 Ops 0-10 and illegal ops SHALL load Q/Flags and set out_valid on the accept edge (latency 1: visible the cycle after accept; throughput 1/cycle with out_ready high).
REQ-017 Op 11 SHALL move FSM IDLE->MUL on accept, run exactly WIDTH shift-add iterations (one per cycle), load Q/Flags and set out_valid on the WIDTH-th MUL edge, then return to IDLE.
REQ-018 out_valid SHALL clear on an edge where out_ready is high and no new result loads; Q/Flags SHALL remain stable while out_valid && !out_ready.
REQ-019 A load and a consume on the same edge SHALL leave out_valid high with the new result.
REQ-020 Z SHALL be (Q==0); N SHALL be Q[WIDTH-1].
REQ-021 C SHALL be carry-out for ops 1 and 7, borrow (A<B unsigned) for op 2, 1 for op 11 when the high WIDTH product bits are nonzero, else 0.
REQ-022 V SHALL be signed two's-complement overflow for ops 1, 2, 7, else 0.
REQ-023 Err SHALL be 1 only for illegal ops, which also give Q=0, C=V=0, Z=1.
REQ-024 Arithmetic SHALL wrap modulo 2^WIDTH.

Reset
REQ-025 With Reset high on an edge: state=IDLE, out_valid=0, Q=0, Flags=0, multiplier counter=0.
REQ-026 Reset SHALL abort an in-flight multiply; no result from it SHALL ever appear.
REQ-027 in_ready SHALL be 0 while Reset is high; the first accept is possible on the edge after Reset falls.

Structure
REQ-028 Package alu_pkg SHALL hold alu_op_e (4-bit enum), alu_flags_t (packed {Err,V,C,N,Z}) and the FSM state enum {IDLE, MUL}.
REQ-029 The multiply SHALL be a sub-module alu_mul_seq (start, done, WIDTH-cycle shift-add, 2*WIDTH product); all else inline.

Verification (WIDTH=16)
REQ-030 Op 1, A=16'hFFFF, B=16'h0001, out_ready=1 -> next cycle Q=16'h0000, Flags: Z=1, C=1, V=0, N=0.
REQ-031 Op 2, A=16'h8000, B=16'h0001 -> Q=16'h7FFF, V=1, C=0, N=0; op 10, A=16'h8000, B=16'd20 -> Q=16'hFFFF, N=1.
REQ-032 Op 11, A=16'h0123, B=16'h0010 -> in_ready low 16 cycles, out_valid exactly 16 edges after accept, Q=16'h1230, C=0; A=B=16'h1000 -> Q=0, C=1, Z=1.
REQ-033 Op 4 result with out_ready=0 for 5 cycles -> Q/Flags/out_valid stable, in_ready=0; out_ready=1 with new in_valid -> back-to-back results, no drop or duplicate.
REQ-034 Reset asserted 5 cycles into an op 11 -> out_valid stays 0, Q=0, Flags=0, in_ready=1 the cycle after Reset falls.
REQ-035 Sel=4'hE, A=16'h1234 -> Q=0, Err=1, Z=1; 200 random accepts vs reference model -> zero mismatches.
